dmem_responder: RTL

- Data-memory responder for the MEM1→MEM2 boundary of the riscv64i pipeline.
- Accepts one load/store request per cycle from MEM1 and performs byte-lane stores into a synchronous 64-bit-wide array.
- Returns load data one cycle later, already lane-extracted and sign/zero-extended. This is the value the MEM2 stage captures as its memory-read word.

---
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder.sv | 73 +++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM1 request / MEM2 response bundle for the data memory responder
interface dmem_responder_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
);
   logic                  stall_i;
   logic                  req_valid_i;
   logic                  req_we_i;
   logic [ADDR_WIDTH-1:0] req_addr_i;
   logic [DATA_WIDTH-1:0] req_wdata_i;
   logic [1:0]            req_size_i;
   logic                  req_unsigned_i;
   logic                  rsp_valid_o;
   logic [DATA_WIDTH-1:0] rsp_rdata_o;
   logic                  misalign_o;
   modport master (
      output stall_i, req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i,
      input  rsp_valid_o, rsp_rdata_o, misalign_o
   );
   modport slave (
      input  stall_i, req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i,
      output rsp_valid_o, rsp_rdata_o, misalign_o
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: byte-lane data memory with 1-cycle extended load response; DMEM_MISALIGN_TRAP_EN traps misaligned accesses
module dmem_responder #(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 64,
   parameter int DEPTH_WORDS = 1024
) (
   input logic             clk_i,
   input logic             rst_i,
   dmem_responder_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
   logic [IDX_W-1:0]      idx;
   logic [2:0]            align, off_eff, off_q, off_d;
   logic [7:0]            be;
   logic [DATA_WIDTH-1:0] wdata_sh, word_q, sh;
   logic                  accept, trap, wr_en, rd_en;
   logic                  valid_q, valid_d, mis_q, mis_d, uns_q, uns_d;
   logic [1:0]            size_q, size_d;
   logic                  unused_addr;
   assign unused_addr = ^bus.req_addr_i[ADDR_WIDTH-1:IDX_W+3];
   always_comb begin
      accept = bus.req_valid_i & ~bus.stall_i & rst_i;
      idx = bus.req_addr_i[IDX_W+2:3];
      align = bus.req_size_i == 2'd0 ? 3'd0 : bus.req_size_i == 2'd1 ? 3'd1 :
              bus.req_size_i == 2'd2 ? 3'd3 : 3'd7;
`ifdef DMEM_MISALIGN_TRAP_EN
      off_eff = bus.req_addr_i[2:0];
      trap = |(bus.req_addr_i[2:0] & align);
`else
      off_eff = bus.req_addr_i[2:0] & ~align;
      trap = 1'b0;
`endif
      be = (bus.req_size_i == 2'd0 ? 8'h01 : bus.req_size_i == 2'd1 ? 8'h03 :
            bus.req_size_i == 2'd2 ? 8'h0F : 8'hFF) << off_eff;
      wdata_sh = bus.req_wdata_i << {off_eff, 3'b000};
      wr_en = accept & bus.req_we_i & ~trap;
      rd_en = accept & ~bus.req_we_i & ~trap;
      valid_d = bus.stall_i ? valid_q : rd_en;
      mis_d = bus.stall_i ? mis_q : accept & trap;
      off_d = bus.stall_i ? off_q : off_eff;
      size_d = bus.stall_i ? size_q : bus.req_size_i;
      uns_d = bus.stall_i ? uns_q : bus.req_unsigned_i;
      sh = word_q >> {off_q, 3'b000};
      bus.rsp_valid_o = valid_q;
      bus.misalign_o = mis_q;
      bus.rsp_rdata_o = !valid_q ? '0 :
         size_q == 2'd0 ? {{56{~uns_q & sh[7]}}, sh[7:0]} :
         size_q == 2'd1 ? {{48{~uns_q & sh[15]}}, sh[15:0]} :
         size_q == 2'd2 ? {{32{~uns_q & sh[31]}}, sh[31:0]} : sh;
   end
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         valid_q <= 1'b0;
         mis_q <= 1'b0;
         uns_q <= 1'b0;
         size_q <= 2'd0;
         off_q <= 3'd0;
      end else begin
         valid_q <= valid_d;
         mis_q <= mis_d;
         uns_q <= uns_d;
         size_q <= size_d;
         off_q <= off_d;
      end
   end
   // Array is never reset; word_q only matters while valid_q is set
   always_ff @(posedge clk_i) begin
      if (rd_en) word_q <= mem[idx];
      for (int i = 0; i < 8; i++)
         if (wr_en && be[i]) mem[idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
   end
endmodule
